// File: rtl/mem_resp_if.sv
// rtl/mem_resp_if.sv - CPU, fast-RAM and I/O bus bundle for mem_resp
interface mem_resp_if;
  // CPU side
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        RDY;
  // fast RAM side
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  // I/O responder side
  logic        io_req;
  logic [7:0]  io_addr;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        io_timeout;

  modport slave (
    input  AB, WE, DO, ram_rdata, io_ack, io_rdata,
    output DI, RDY, ram_addr, ram_we, ram_wdata,
           io_req, io_addr, io_we, io_wdata, io_timeout
  );

  modport master (
    output AB, WE, DO, ram_rdata, io_ack, io_rdata,
    input  DI, RDY, ram_addr, ram_we, ram_wdata,
           io_req, io_addr, io_we, io_wdata, io_timeout
  );
endinterface

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - zero-wait fast RAM responder with slow I/O page, wait states and timeout
module mem_resp #(
  parameter logic [7:0] IO_PAGE = 8'hFE,
  parameter int         TIMEOUT = 8
) (
  input logic       clk,
  input logic       rst,
  mem_resp_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  // Last count value at which an unanswered request is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       io_hit;
  logic       rdy;
  logic       ram_we;
  logic       ack_take;
  logic       tmo_take;
  logic       sel_io;
  logic [7:0] io_hold;
  logic       io_req_q;
  logic [7:0] io_addr_q;
  logic       io_we_q;
  logic [7:0] io_wdata_q;
  logic       io_timeout_q;

  assign io_hit         = (bus.AB[15:8] == IO_PAGE);
  assign bus.ram_addr   = bus.AB;
  assign bus.ram_wdata  = bus.DO;
  assign bus.RDY        = rdy;
  assign bus.ram_we     = ram_we;
  assign bus.DI         = sel_io ? io_hold : bus.ram_rdata;
  assign bus.io_req     = io_req_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_we      = io_we_q;
  assign bus.io_wdata   = io_wdata_q;
  assign bus.io_timeout = io_timeout_q;

  // Next-state and handshake decode; io_ack only matters while requesting.
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    ram_we   = 1'b0;
    ack_take = 1'b0;
    tmo_take = 1'b0;
    case (state)
      S_IDLE: begin
        rdy    = !io_hit;
        ram_we = bus.WE & !io_hit;
        if (io_hit) state_nx = S_REQ;
      end
      S_REQ: begin
        if (bus.io_ack) begin
          ack_take = 1'b1;
          state_nx = S_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_take = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        rdy      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Capture the I/O access parameters when it is first seen in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_addr_q  <= 8'h00;
      io_we_q    <= 1'b0;
      io_wdata_q <= 8'h00;
    end else if (state == S_IDLE && io_hit) begin
      io_addr_q  <= bus.AB[7:0];
      io_we_q    <= bus.WE;
      io_wdata_q <= bus.DO;
    end
  end

  // Wait-cycle counter for the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= 8'h00;
    else if (state == S_IDLE && io_hit)               cnt <= 8'h00;
    else if (state == S_REQ && !ack_take && !tmo_take) cnt <= cnt + 8'h01;
  end

  // Registered request and timeout flags; both follow the state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_req_q     <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      io_req_q     <= (state_nx == S_REQ);
      io_timeout_q <= tmo_take;
    end
  end

  // Read data holding register; writes never disturb it, a timed-out read returns FF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       io_hold <= 8'h00;
    else if (ack_take && !io_we_q) io_hold <= bus.io_rdata;
    else if (tmo_take && !io_we_q) io_hold <= 8'hFF;
  end

  // Remember which source the completed access used so DI steers correctly next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sel_io <= 1'b0;
    else if (rdy) sel_io <= io_hit;
  end

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - self-checking bench for mem_resp
module tb_mem_resp;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_resp_if bus();

  mem_resp #(.IO_PAGE(8'hFE), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectations written by the driver, consumed by the compare process.
  logic       chk_en = 1'b0;
  logic       exp_rdy, exp_ram_we, exp_io_req, exp_tmo;
  logic       exp_di_v = 1'b0;
  logic [7:0] exp_di;
  logic       exp_f_v = 1'b0;
  logic [7:0] exp_io_addr, exp_io_wdata;
  logic       exp_io_we;

  int req_cnt, rdy_low_cnt, tmo_cnt, ram_we_cnt;

  // Transaction-level model state.
  logic [7:0] model_hold = 8'h00;
  logic       pend_v     = 1'b0;
  logic [7:0] pend_di    = 8'h00;
  logic [7:0] pend_ram   = 8'h00;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdy", {15'd0, bus.RDY}, {15'd0, exp_rdy});
      chk("ram_we", {15'd0, bus.ram_we}, {15'd0, exp_ram_we});
      chk("io_req", {15'd0, bus.io_req}, {15'd0, exp_io_req});
      chk("io_timeout", {15'd0, bus.io_timeout}, {15'd0, exp_tmo});
      chk("ram_addr", bus.ram_addr, bus.AB);
      chk("ram_wdata", {8'd0, bus.ram_wdata}, {8'd0, bus.DO});
      if (exp_di_v) chk("di", {8'd0, bus.DI}, {8'd0, exp_di});
      if (exp_f_v) begin
        chk("io_addr", {8'd0, bus.io_addr}, {8'd0, exp_io_addr});
        chk("io_we", {15'd0, bus.io_we}, {15'd0, exp_io_we});
        chk("io_wdata", {8'd0, bus.io_wdata}, {8'd0, exp_io_wdata});
      end
      if (bus.io_req === 1'b1)     req_cnt++;
      if (bus.RDY !== 1'b1)        rdy_low_cnt++;
      if (bus.io_timeout === 1'b1) tmo_cnt++;
      if (bus.ram_we === 1'b1)     ram_we_cnt++;
    end
  end

  task automatic clr_cnt();
    req_cnt = 0; rdy_low_cnt = 0; tmo_cnt = 0; ram_we_cnt = 0;
  endtask

  // Present the read data owed by the previous completed access.
  task automatic present_pending();
    bus.ram_rdata = pend_ram;
    exp_di_v      = pend_v;
    exp_di        = pend_di;
  endtask

  // One CPU access. ack_at: REQ cycle (1-based) carrying io_ack, 0 = never.
  // spur: also pulse io_ack with junk data in the IDLE and DONE cycles.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic [7:0] rd, input int ack_at, input logic [7:0] ackd,
                        input logic spur);
    logic io;
    logic tmo;
    int   nreq;
    io = (a[15:8] == 8'hFE);
    present_pending();
    bus.AB = a; bus.WE = w; bus.DO = d;
    bus.io_ack   = spur;
    bus.io_rdata = spur ? 8'h99 : 8'h00;
    exp_rdy = !io; exp_ram_we = w & !io; exp_io_req = 1'b0; exp_tmo = 1'b0; exp_f_v = 1'b0;
    @(posedge clk); #1;
    exp_di_v = 1'b0;
    if (!io) begin
      pend_v = 1'b1; pend_di = rd; pend_ram = rd;
    end else begin
      tmo  = (ack_at == 0) || (ack_at > TO);
      nreq = tmo ? TO : ack_at;
      exp_io_addr = a[7:0]; exp_io_we = w; exp_io_wdata = d; exp_f_v = 1'b1;
      bus.ram_rdata = 8'hEE;
      for (int k = 1; k <= nreq; k++) begin
        bus.io_ack   = (k == ack_at);
        bus.io_rdata = (k == ack_at) ? ackd : 8'h5F;
        exp_rdy = 1'b0; exp_ram_we = 1'b0; exp_io_req = 1'b1; exp_tmo = 1'b0;
        @(posedge clk); #1;
      end
      bus.io_ack   = spur;
      bus.io_rdata = 8'h99;
      exp_rdy = 1'b1; exp_ram_we = 1'b0; exp_io_req = 1'b0; exp_tmo = tmo;
      if (!w) model_hold = tmo ? 8'hFF : ackd;
      @(posedge clk); #1;
      bus.io_ack = 1'b0;
      pend_v = 1'b1; pend_di = model_hold; pend_ram = 8'hEE;
    end
  endtask

  initial begin
    bus.AB = 16'h0000; bus.WE = 1'b1; bus.DO = 8'h00;
    bus.ram_rdata = 8'h77; bus.io_ack = 1'b0; bus.io_rdata = 8'h00;
    #1 rst = 1'b1;
    #20;
    chk("rst_io_req", {15'd0, bus.io_req}, 16'd0);
    chk("rst_io_timeout", {15'd0, bus.io_timeout}, 16'd0);
    chk("rst_io_addr", {8'd0, bus.io_addr}, 16'h0000);
    chk("rst_io_we", {15'd0, bus.io_we}, 16'd0);
    chk("rst_io_wdata", {8'd0, bus.io_wdata}, 16'h0000);
    chk("rst_di", {8'd0, bus.DI}, 16'h0077);
    chk("rst_rdy_fast", {15'd0, bus.RDY}, 16'd1);
    chk("rst_ram_we_fast", {15'd0, bus.ram_we}, 16'd1);
    bus.AB = 16'hFE00;
    #1;
    chk("rst_rdy_io", {15'd0, bus.RDY}, 16'd0);
    chk("rst_ram_we_io", {15'd0, bus.ram_we}, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;

    // Fast read, then DI shows the RAM byte.
    clr_cnt();
    access(16'h1234, 1'b0, 8'h00, 8'h5A, 0, 8'h00, 1'b0);
    present_pending(); #1;
    chk("fast_di", {8'd0, bus.DI}, 16'h005A);
    chk("fast_ram_addr", bus.ram_addr, 16'h1234);

    // Zero-wait fast write and back-to-back reads.
    clr_cnt();
    access(16'h3000, 1'b1, 8'h99, 8'h00, 0, 8'h00, 1'b0);
    access(16'h0010, 1'b0, 8'h00, 8'h01, 0, 8'h00, 1'b0);
    access(16'h0011, 1'b0, 8'h00, 8'h02, 0, 8'h00, 1'b0);
    chk("b2b_rdy_low", 16'(rdy_low_cnt), 16'd0);
    chk("b2b_ram_we", 16'(ram_we_cnt), 16'd1);

    // I/O write acked in the second REQ cycle.
    clr_cnt();
    access(16'hFE10, 1'b1, 8'h3C, 8'h00, 2, 8'h00, 1'b0);
    chk("iow_addr", {8'd0, bus.io_addr}, 16'h0010);
    chk("iow_we", {15'd0, bus.io_we}, 16'd1);
    chk("iow_wdata", {8'd0, bus.io_wdata}, 16'h003C);
    chk("iow_req_cycles", 16'(req_cnt), 16'd2);
    chk("iow_rdy_low", 16'(rdy_low_cnt), 16'd3);
    chk("iow_ram_we", 16'(ram_we_cnt), 16'd0);

    // I/O read that times out.
    clr_cnt();
    access(16'hFE30, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0);
    chk("tmo_req_cycles", 16'(req_cnt), 16'd8);
    chk("tmo_flag_cycles", 16'(tmo_cnt), 16'd1);
    present_pending(); #1;
    chk("tmo_di", {8'd0, bus.DI}, 16'h00FF);

    // I/O read, fast read, I/O write: io_hold keeps the I/O read byte.
    access(16'hFE40, 1'b0, 8'h00, 8'h00, 1, 8'hA7, 1'b0);
    present_pending(); #1;
    chk("ior_di", {8'd0, bus.DI}, 16'h00A7);
    access(16'h2000, 1'b0, 8'h00, 8'h11, 0, 8'h00, 1'b0);
    present_pending(); #1;
    chk("fast_after_io_di", {8'd0, bus.DI}, 16'h0011);
    access(16'hFE50, 1'b1, 8'h55, 8'h00, 3, 8'h00, 1'b0);
    present_pending(); #1;
    chk("hold_after_iow", {8'd0, bus.DI}, 16'h00A7);

    // Ack on the last allowed cycle, plus ignored acks in IDLE and DONE.
    clr_cnt();
    access(16'hFE60, 1'b0, 8'h00, 8'h00, TO, 8'h42, 1'b1);
    chk("edge_req_cycles", 16'(req_cnt), 16'd8);
    chk("edge_tmo", 16'(tmo_cnt), 16'd0);
    present_pending(); #1;
    chk("edge_di", {8'd0, bus.DI}, 16'h0042);

    // Back-to-back I/O reads.
    clr_cnt();
    access(16'hFE70, 1'b0, 8'h00, 8'h00, 2, 8'h13, 1'b0);
    access(16'hFE71, 1'b0, 8'h00, 8'h00, 1, 8'h24, 1'b0);
    chk("b2b_io_req_cycles", 16'(req_cnt), 16'd3);
    present_pending(); #1;
    chk("b2b_io_di", {8'd0, bus.DI}, 16'h0024);

    // Reset during REQ aborts; the held address then restarts cleanly.
    chk_en = 1'b0;
    bus.AB = 16'hFE20; bus.WE = 1'b0; bus.DO = 8'h00; bus.io_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_pre", {15'd0, bus.io_req}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_io_req", {15'd0, bus.io_req}, 16'd0);
    chk("mid_rst_rdy", {15'd0, bus.RDY}, 16'd0);
    chk("mid_rst_ram_we", {15'd0, bus.ram_we}, 16'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_req", {15'd0, bus.io_req}, 16'd0);
    rst = 1'b0;
    pend_v = 1'b0; model_hold = 8'h00;
    chk_en = 1'b1;
    clr_cnt();
    access(16'hFE20, 1'b0, 8'h00, 8'h00, 1, 8'h5C, 1'b0);
    chk("restart_req_cycles", 16'(req_cnt), 16'd1);
    chk("restart_rdy_low", 16'(rdy_low_cnt), 16'd2);
    present_pending(); #1;
    chk("restart_di", {8'd0, bus.DI}, 16'h005C);

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
